adder_axil_driver: RTL and testbench
====================================

// Module: adder_axil_driver
// PURPOSE
// AXI4-Lite master that sits upstream of the adder AXI-slave top and drives its S_AXI port.
// Takes one operation request (A, B, op) on a valid/ready port and runs the full register sequence:
// write R0, write R1, write CTRL with start, poll STATUS until done, read RESULT.
// Returns the result or an error on a valid/ready response port. One operation in flight at a time.
// PARAMETERS
// ADDR_WIDTH   32     AXI address width
// DATA_WIDTH   32     AXI data width; only 32 is supported
// BASE_ADDR    0      slave base; map: +0x00 R0, +0x04 R1, +0x08 CTRL, +0x0C STATUS, +0x10 RESULT
// POLL_LIMIT   1024   max STATUS reads per operation before timeout; must be >= 1
// PORTS
// ACLK            in   1    clock
// ARSTn           in   1    reset; asynchronous, active-low
// i_req_valid     in   1    request valid
// o_req_ready     out  1    request ready
// i_req_a         in   32   operand A, written to R0
// i_req_b         in   32   operand B, written to R1
// i_req_op        in   1    operation select, written to CTRL[1]
// o_rsp_valid     out  1    response valid
// i_rsp_ready     in   1    response ready
// o_rsp_result    out  32   RESULT register value
// o_rsp_err       out  1    1 = bus error or poll timeout
// M_AXI_AWADDR    out  AW   write address
// M_AXI_AWVALID   out  1    write address valid
// M_AXI_AWREADY   in   1    write address ready
// M_AXI_WDATA     out  32   write data
// M_AXI_WSTRB     out  4    write strobe; constant 4'hF
// M_AXI_WVALID    out  1    write data valid
// M_AXI_WREADY    in   1    write data ready
// M_AXI_BRESP     in   2    write response
// M_AXI_BVALID    in   1    write response valid
// M_AXI_BREADY    out  1    write response ready
// M_AXI_ARADDR    out  AW   read address
// M_AXI_ARVALID   out  1    read address valid
// M_AXI_ARREADY   in   1    read address ready
// M_AXI_RDATA     in   32   read data
// M_AXI_RRESP     in   2    read response
// M_AXI_RVALID    in   1    read data valid
// M_AXI_RREADY    out  1    read data ready
// M_AXI_AWPROT/ARPROT  out  3 each  constant 3'b000
// BEHAVIOUR
// - Reset (async, ARSTn=0): state IDLE; all VALID/READY outputs 0; o_rsp_* 0; addresses and WDATA 0; poll count 0.
// - FSM: IDLE -> WR_R0 -> WR_R1 -> WR_CTRL -> RD_STAT (loop) -> RD_RES -> RESP -> IDLE.
// - IDLE: o_req_ready=1 (only in IDLE). On i_req_valid & o_req_ready, latch A/B/op and go to WR_R0.
// - Write states:
//   - Entry: AWVALID=1 and WVALID=1 together. Each drops the cycle after its own handshake; AW and W may complete in either order.
//   - BREADY=1 once both AW and W are done. The state completes on the B handshake.
//   - Data: CTRL word = {30'b0, op, 1'b1}.
// - Read states:
//   - Entry: ARVALID=1 until ARREADY. RREADY=1 after the AR handshake. The state completes on the R handshake.
// - RD_STAT:
//   - RDATA[0]=1 -> RD_RES.
//   - RDATA[0]=0 -> increment poll count. If count==POLL_LIMIT -> RESP with err=1, result=0; else reissue the STATUS read on the next cycle.
// - Errors: BRESP!=2'b00 or RRESP!=2'b00 in any state -> RESP, err=1, result=0. No further bus transactions for that operation.
// - RD_RES: RDATA latched into o_rsp_result, err=0 -> RESP.
// - RESP: o_rsp_valid=1; result/err held stable until i_rsp_ready. On the handshake, return to IDLE and clear poll count.
// - Latency: each AXI transaction takes >= 2 cycles (address/data handshake, then response). Request-to-response is >= 10 cycles with a zero-wait slave and done on the first poll.
// - Never more than one outstanding transaction. A new request is not accepted while o_rsp_valid=1.
// - i_req_* changes after acceptance have no effect.
// - Reset mid-operation aborts immediately; the slave shares ARSTn, so the dropped transaction is legal.
// TESTING
// 1. Zero-wait slave model, A=5, B=7, op=0, done on first poll -> AW addrs 0x00,0x04,0x08 with data 5,7,0x1; one STATUS read; RESULT read; rsp result=12, err=0.
// 2. Slave holds AWREADY low 3 cycles while WREADY is immediate -> WVALID drops first, AWVALID is held stable, BREADY rises only after both handshakes; sequence completes correctly.
// 3. STATUS returns 0 four times, then 1 -> exactly 5 STATUS reads, then RESULT read; err=0.
// 4. POLL_LIMIT=4, STATUS stuck at 0 -> exactly 4 STATUS reads, no RESULT read, rsp err=1, result=0.
// 5. BRESP=2'b10 on the R1 write -> no CTRL write issued; rsp err=1. i_rsp_ready held low 5 cycles -> rsp stays stable; o_req_ready=0 throughout.
// 6. ARSTn pulsed low during RD_STAT -> all AXI valids 0 in the same cycle, FSM in IDLE, o_req_ready=1 after release; the next request completes normally.

Source files
------------

// File: rtl/adder_axil_driver.sv
// AXI4-Lite master that runs one adder operation end to end:
// write R0, R1, CTRL(start), poll STATUS until done, read RESULT, then return it.
module adder_axil_driver #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           POLL_LIMIT = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARSTn,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [DATA_WIDTH-1:0]   i_req_a,
    input  logic [DATA_WIDTH-1:0]   i_req_b,
    input  logic                    i_req_op,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_result,
    output logic                    o_rsp_err,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [3:0]              M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY,
    output logic [2:0]              M_AXI_AWPROT,
    output logic [2:0]              M_AXI_ARPROT
);
    localparam int unsigned CW = $clog2(POLL_LIMIT + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_R0   = ADDR_WIDTH'(BASE_ADDR + ADDR_WIDTH'(32'h00));
    localparam logic [ADDR_WIDTH-1:0] ADDR_R1   = ADDR_WIDTH'(BASE_ADDR + ADDR_WIDTH'(32'h04));
    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL = ADDR_WIDTH'(BASE_ADDR + ADDR_WIDTH'(32'h08));
    localparam logic [ADDR_WIDTH-1:0] ADDR_STAT = ADDR_WIDTH'(BASE_ADDR + ADDR_WIDTH'(32'h0C));
    localparam logic [ADDR_WIDTH-1:0] ADDR_RES  = ADDR_WIDTH'(BASE_ADDR + ADDR_WIDTH'(32'h10));

    typedef enum logic [2:0] {
        IDLE, WR_R0, WR_R1, WR_CTRL, RD_STAT, RD_RES, RESP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic                  op_q, op_d;
    logic [CW-1:0]         poll_q, poll_d;
    logic                  aw_done_q, aw_done_d, w_done_q, w_done_d, ar_done_q, ar_done_d;
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                  arvalid_q, arvalid_d, rready_q, rready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, result_q, result_d;
    logic                  req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, err_q, err_d;
    logic                  b_hs, r_hs, fail;

    assign b_hs = bready_q & M_AXI_BVALID;
    assign r_hs = rready_q & M_AXI_RVALID;

    // Next-state and next-output logic; every register has its hold value as default.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        poll_d      = poll_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        araddr_d    = araddr_q;
        result_d    = result_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        fail        = 1'b0;
        // Per-channel handshake tracking shared by all write and read states.
        aw_done_d   = aw_done_q | (awvalid_q & M_AXI_AWREADY);
        w_done_d    = w_done_q  | (wvalid_q  & M_AXI_WREADY);
        ar_done_d   = ar_done_q | (arvalid_q & M_AXI_ARREADY);
        awvalid_d   = awvalid_q & ~M_AXI_AWREADY;
        wvalid_d    = wvalid_q  & ~M_AXI_WREADY;
        arvalid_d   = arvalid_q & ~M_AXI_ARREADY;
        bready_d    = aw_done_d & w_done_d & ~b_hs;
        rready_d    = ar_done_d & ~r_hs;
        if (b_hs) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end
        if (r_hs) begin
            ar_done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (i_req_valid && req_ready_q) begin
                    a_d       = i_req_a;
                    b_d       = i_req_b;
                    op_d      = i_req_op;
                    state_d   = WR_R0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = ADDR_R0;
                    wdata_d   = i_req_a;
                end
            end
            WR_R0, WR_R1, WR_CTRL: begin
                if (b_hs) begin
                    if (M_AXI_BRESP != 2'b00) begin
                        fail = 1'b1;
                    end else if (state_q == WR_CTRL) begin
                        state_d   = RD_STAT;
                        arvalid_d = 1'b1;
                        araddr_d  = ADDR_STAT;
                    end else begin
                        state_d   = (state_q == WR_R0) ? WR_R1 : WR_CTRL;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = (state_q == WR_R0) ? ADDR_R1 : ADDR_CTRL;
                        wdata_d   = (state_q == WR_R0) ? b_q
                                  : {{(DATA_WIDTH-2){1'b0}}, op_q, 1'b1};
                    end
                end
            end
            RD_STAT: begin
                if (r_hs) begin
                    if (M_AXI_RRESP != 2'b00) begin
                        fail = 1'b1;
                    end else if (M_AXI_RDATA[0]) begin
                        state_d   = RD_RES;
                        arvalid_d = 1'b1;
                        araddr_d  = ADDR_RES;
                    end else begin
                        poll_d = poll_q + CW'(1);
                        if (poll_d == CW'(POLL_LIMIT)) begin
                            fail = 1'b1;
                        end else begin
                            arvalid_d = 1'b1;
                        end
                    end
                end
            end
            RD_RES: begin
                if (r_hs) begin
                    if (M_AXI_RRESP != 2'b00) begin
                        fail = 1'b1;
                    end else begin
                        state_d     = RESP;
                        result_d    = M_AXI_RDATA;
                        err_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_valid_q && i_rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    poll_d      = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus error or poll timeout: report and issue nothing further.
        if (fail) begin
            state_d     = RESP;
            result_d    = '0;
            err_d       = 1'b1;
            rsp_valid_d = 1'b1;
        end
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            poll_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            ar_done_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            araddr_q    <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            poll_q      <= poll_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            ar_done_q   <= ar_done_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            araddr_q    <= araddr_d;
            result_q    <= result_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign o_req_ready   = req_ready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_result  = result_q;
    assign o_rsp_err     = err_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;

endmodule

// File: tb/tb_adder_axil_driver.sv
// Bench for adder_axil_driver: two instances (POLL_LIMIT 1024 and 4) share one
// behavioural AXI4-Lite adder slave through a select mux.
module tb_adder_axil_driver;

    logic        clk, rst_n, sel;
    logic        req_valid, req_op, rsp_ready;
    logic [31:0] req_a, req_b;

    logic [1:0]  req_ready_v, rsp_valid_v, rsp_err_v;
    logic [1:0]  awvalid_v, wvalid_v, bready_v, arvalid_v, rready_v;
    logic [31:0] rsp_result_v [2];
    logic [31:0] awaddr_v [2];
    logic [31:0] wdata_v [2];
    logic [31:0] araddr_v [2];
    logic [3:0]  wstrb_v [2];
    logic [2:0]  awprot_v [2];
    logic [2:0]  arprot_v [2];

    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        adder_axil_driver #(
            .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0),
            .POLL_LIMIT(g == 0 ? 1024 : 4)
        ) u_dut (
            .ACLK(clk), .ARSTn(rst_n),
            .i_req_valid(req_valid && (sel == 1'(g))), .o_req_ready(req_ready_v[g]),
            .i_req_a(req_a), .i_req_b(req_b), .i_req_op(req_op),
            .o_rsp_valid(rsp_valid_v[g]), .i_rsp_ready(rsp_ready && (sel == 1'(g))),
            .o_rsp_result(rsp_result_v[g]), .o_rsp_err(rsp_err_v[g]),
            .M_AXI_AWADDR(awaddr_v[g]), .M_AXI_AWVALID(awvalid_v[g]), .M_AXI_AWREADY(awready),
            .M_AXI_WDATA(wdata_v[g]), .M_AXI_WSTRB(wstrb_v[g]), .M_AXI_WVALID(wvalid_v[g]),
            .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
            .M_AXI_BREADY(bready_v[g]), .M_AXI_ARADDR(araddr_v[g]), .M_AXI_ARVALID(arvalid_v[g]),
            .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
            .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready_v[g]),
            .M_AXI_AWPROT(awprot_v[g]), .M_AXI_ARPROT(arprot_v[g])
        );
    end

    logic        req_ready, rsp_valid, rsp_err, awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] rsp_result, awaddr, wdata, araddr;
    assign req_ready  = req_ready_v[sel];
    assign rsp_valid  = rsp_valid_v[sel];
    assign rsp_err    = rsp_err_v[sel];
    assign rsp_result = rsp_result_v[sel];
    assign awvalid    = awvalid_v[sel];
    assign wvalid     = wvalid_v[sel];
    assign bready     = bready_v[sel];
    assign arvalid    = arvalid_v[sel];
    assign rready     = rready_v[sel];
    assign awaddr     = awaddr_v[sel];
    assign wdata      = wdata_v[sel];
    assign araddr     = araddr_v[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave configuration and observation log.
    int          cfg_aw_wait, cfg_zeros;
    logic        cfg_stuck, cfg_bad_b, log_clr;
    int          wr_cnt, stat_rd, res_rd, aw_cnt;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_r0, s_r1;
    logic        s_op, got_aw, got_w, ar_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready <= 0; wready <= 0; bvalid <= 0; bresp <= 0;
            arready <= 0; rvalid <= 0; rresp <= 0; rdata <= 0;
            got_aw <= 0; got_w <= 0; ar_pend <= 0; aw_cnt <= 0;
        end else begin
            awready <= 0; wready <= 0; arready <= 0;
            if (awvalid && !awready && !got_aw) begin
                if (aw_cnt >= cfg_aw_wait) awready <= 1;
                else aw_cnt <= aw_cnt + 1;
            end
            if (awvalid && awready) begin got_aw <= 1; aw_cnt <= 0; s_awaddr <= awaddr; end
            if (wvalid && !wready && !got_w) wready <= 1;
            if (wvalid && wready) begin got_w <= 1; s_wdata <= wdata; end
            if (got_aw && got_w && !bvalid) begin
                bvalid <= 1;
                bresp  <= (cfg_bad_b && s_awaddr == 32'h4) ? 2'b10 : 2'b00;
                if (wr_cnt < 16) begin
                    wr_addr[wr_cnt] <= s_awaddr;
                    wr_data[wr_cnt] <= s_wdata;
                end
                wr_cnt <= wr_cnt + 1;
                if (s_awaddr == 32'h0) s_r0 <= s_wdata;
                if (s_awaddr == 32'h4) s_r1 <= s_wdata;
                if (s_awaddr == 32'h8) s_op <= s_wdata[1];
            end
            if (bvalid && bready) begin bvalid <= 0; got_aw <= 0; got_w <= 0; end
            if (arvalid && !arready && !ar_pend && !rvalid) arready <= 1;
            if (arvalid && arready) begin ar_pend <= 1; s_araddr <= araddr; end
            if (ar_pend && !rvalid) begin
                rvalid <= 1;
                rresp  <= 2'b00;
                if (s_araddr == 32'hC) begin
                    rdata   <= {31'b0, (!cfg_stuck && stat_rd >= cfg_zeros)};
                    stat_rd <= stat_rd + 1;
                end else if (s_araddr == 32'h10) begin
                    rdata  <= s_op ? (s_r0 - s_r1) : (s_r0 + s_r1);
                    res_rd <= res_rd + 1;
                end else begin
                    rdata <= 32'h0;
                end
            end
            if (rvalid && rready) begin rvalid <= 0; ar_pend <= 0; end
        end
        if (log_clr) begin wr_cnt <= 0; stat_rd <= 0; res_rd <= 0; end
    end

    // Protocol monitor sampled on the falling edge.
    int          bready_early, w_first, aw_unstable, overlap;
    logic        prev_awv;
    logic [31:0] prev_awaddr;
    always @(negedge clk) begin
        if (log_clr) begin
            bready_early <= 0; w_first <= 0; aw_unstable <= 0; overlap <= 0; prev_awv <= 0;
        end else begin
            if (bready && (awvalid || wvalid)) bready_early <= bready_early + 1;
            if (awvalid && !wvalid) w_first <= w_first + 1;
            if (awvalid && prev_awv && awaddr != prev_awaddr) aw_unstable <= aw_unstable + 1;
            if ((awvalid || wvalid || bready) && (arvalid || rready)) overlap <= overlap + 1;
            prev_awv    <= awvalid;
            prev_awaddr <= awaddr;
        end
    end

    int checks, failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic pulse_clr();
        log_clr = 1'b1;
        @(posedge clk); #1;
        log_clr = 1'b0;
    endtask

    logic [31:0] got_res;
    logic        got_err;
    int          lat;

    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic op);
        int n;
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_a = 32'hDEAD_BEEF; req_b = 32'hCAFE_F00D; req_op = ~op;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                          input int hold);
        logic stable;
        pulse_clr();
        accept(a, b, op);
        lat = 1;
        while (!rsp_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
        check("rsp_valid_wait", 32'(rsp_valid), 32'd1);
        got_res = rsp_result;
        got_err = rsp_err;
        stable  = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_result !== got_res || rsp_err !== got_err || req_ready)
                stable = 1'b0;
        end
        if (hold > 0) check("rsp_hold_stable", 32'(stable), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
        check("req_ready_after_rsp", 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        logic        sel;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        int          zeros;
        logic        stuck;
        int          aw_wait;
        logic        bad_b;
        int          hold;
        logic [31:0] exp_res;
        logic        exp_err;
        int          exp_wr;
        int          exp_stat;
        int          exp_res_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = 1'b0;
        rsp_ready = 1'b0; log_clr = 1'b0;
        cfg_aw_wait = 0; cfg_zeros = 0; cfg_stuck = 1'b0; cfg_bad_b = 1'b0;
        wr_cnt = 0; stat_rd = 0; res_rd = 0;

        //            sel  a             b         op  zeros stuck aww bad hold res         err wr stat res
        vecs[0] = '{1'b0, 32'd5,        32'd7,    1'b0, 0, 1'b0, 0, 1'b0, 0, 32'd12,     1'b0, 3, 1, 1};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'd1,   1'b0, 0, 1'b0, 0, 1'b0, 0, 32'd0,      1'b0, 3, 1, 1};
        vecs[2] = '{1'b0, 32'd100,      32'd30,   1'b1, 0, 1'b0, 0, 1'b0, 0, 32'd70,     1'b0, 3, 1, 1};
        vecs[3] = '{1'b0, 32'h1234,     32'h1111, 1'b0, 0, 1'b0, 3, 1'b0, 0, 32'h2345,   1'b0, 3, 1, 1};
        vecs[4] = '{1'b0, 32'd1,        32'd2,    1'b0, 4, 1'b0, 0, 1'b0, 0, 32'd3,      1'b0, 3, 5, 1};
        vecs[5] = '{1'b1, 32'd8,        32'd8,    1'b0, 0, 1'b1, 0, 1'b0, 0, 32'd0,      1'b1, 3, 4, 0};
        vecs[6] = '{1'b0, 32'd9,        32'd9,    1'b0, 0, 1'b0, 0, 1'b1, 5, 32'd0,      1'b1, 2, 0, 0};
        vecs[7] = '{1'b1, 32'd3,        32'd4,    1'b0, 3, 1'b0, 0, 1'b0, 0, 32'd7,      1'b0, 3, 4, 1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_valids", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 32'd0);
        check("reset_awaddr", awaddr, 32'd0);
        check("reset_wdata", wdata, 32'd0);
        check("reset_rsp", {rsp_result[30:0], rsp_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("req_ready_after_reset", 32'(req_ready), 32'd1);
        check("wstrb_const", 32'(wstrb_v[0]), 32'hF);
        check("prot_const", 32'({awprot_v[0], arprot_v[0]}), 32'd0);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] ed;
            sel = vecs[i].sel;
            cfg_zeros = vecs[i].zeros; cfg_stuck = vecs[i].stuck;
            cfg_aw_wait = vecs[i].aw_wait; cfg_bad_b = vecs[i].bad_b;
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].hold);
            check($sformatf("v%0d_result", i), got_res, vecs[i].exp_res);
            check($sformatf("v%0d_err", i), 32'(got_err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_writes", i), 32'(wr_cnt), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d_status_reads", i), 32'(stat_rd), 32'(vecs[i].exp_stat));
            check($sformatf("v%0d_result_reads", i), 32'(res_rd), 32'(vecs[i].exp_res_rd));
            for (int k = 0; k < wr_cnt && k < 3; k++) begin
                ed = (k == 0) ? vecs[i].a : (k == 1) ? vecs[i].b : {30'b0, vecs[i].op, 1'b1};
                check($sformatf("v%0d_wr%0d_addr", i, k), wr_addr[k], 32'(k * 4));
                check($sformatf("v%0d_wr%0d_data", i, k), wr_data[k], ed);
            end
            if (!vecs[i].exp_err) check($sformatf("v%0d_latency_ge10", i), 32'(lat >= 10), 32'd1);
            check($sformatf("v%0d_w_first", i), 32'(w_first > 0), 32'(vecs[i].aw_wait > 0));
            check($sformatf("v%0d_bready_early", i), 32'(bready_early), 32'd0);
            check($sformatf("v%0d_aw_unstable", i), 32'(aw_unstable), 32'd0);
            check($sformatf("v%0d_overlap", i), 32'(overlap), 32'd0);
        end

        // Reset while polling STATUS, then a clean operation.
        begin
            int n;
            sel = 1'b0; cfg_stuck = 1'b1; cfg_zeros = 0; cfg_aw_wait = 0; cfg_bad_b = 1'b0;
            pulse_clr();
            accept(32'd40, 32'd2, 1'b0);
            n = 0;
            while (!(stat_rd >= 2 && (arvalid || rready)) && n < 500) begin
                @(posedge clk); #1; n++;
            end
            check("reached_poll", 32'(stat_rd >= 2), 32'd1);
            rst_n = 1'b0;
            #1;
            check("abort_valids",
                  32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, req_ready}), 32'd0);
            @(posedge clk); @(posedge clk); #1;
            rst_n = 1'b1; cfg_stuck = 1'b0;
            @(posedge clk); #1;
            check("abort_req_ready", 32'(req_ready), 32'd1);
            run_op(32'd40, 32'd2, 1'b1, 0);
            check("post_abort_result", got_res, 32'd38);
            check("post_abort_err", 32'(got_err), 32'd0);
            check("post_abort_status_reads", 32'(stat_rd), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
